// File: rtl/bram_mac_sequencer_pkg.sv
// Shared definitions for the BRAM operand-pair MAC sequencer.
// Holds the controller state encoding, the default operand/address widths
// and the accumulator width derivation used by the top-level parameter list.
package bram_mac_sequencer_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_MUL,
    S_OUT,
    S_DONE
  } state_t;

  // A full run is at most 2^addr_w full-scale products, each below 2^(2*data_w),
  // so this width can never overflow.
  function automatic int acc_width(input int data_w, input int addr_w);
    return 2 * data_w + addr_w;
  endfunction

endpackage

// File: rtl/bram_mac_sequencer_mul.sv
// seq_multiplier: unsigned iterative shift-add multiplier.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   start       loads a/b and clears the partial product
//   a, b        operands (a = multiplicand, b = multiplier)
//   done        high during the final iteration cycle
//   product     finished 2*DATA_W product, valid while done is high
// After start, exactly DATA_W iteration cycles follow, one multiplier bit each.
module seq_multiplier #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [2*DATA_W-1:0] part_q, part_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                run_q, run_d;
  logic [2*DATA_W-1:0] sum;

  always_comb begin
    sum      = part_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = mcand_q;
    part_d   = part_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done     = 1'b0;
    if (start) begin
      mcand_d  = {{DATA_W{1'b0}}, a};
      mplier_d = b;
      part_d   = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      part_d   = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DATA_W - 1)) begin
        run_d = 1'b0;
        done  = 1'b1;
      end
    end
  end

  // The last partial sum is handed out combinationally so the caller can
  // register it in the same cycle the final bit is processed.
  assign product = sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      part_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      part_q   <= part_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/bram_mac_sequencer.sv
// bram_mac_sequencer: walks len addresses from base_addr through operand
// memories A and B, multiplies each pair and streams per-pair products
// (mode_acc=0) or running MAC totals (mode_acc=1) over valid/ready.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   start, mode_acc, base_addr,
//   len                          run request, sampled only in IDLE
//   mem_en, mem_addr             shared read port to both memories
//   rd_a, rd_b                   read data, valid one cycle after mem_en
//   res_data, res_valid,
//   res_ready, res_last          result stream
//   busy, done                   status (done = one-cycle completion pulse)
// Every output is a flop whose next value is derived from the next state,
// so res_ready has no combinational path to any output.
module bram_mac_sequencer
  import bram_mac_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ACC_W  = acc_width(DATA_W, ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_acc,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] rd_a,
  input  logic [DATA_W-1:0] rd_b,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_last,
  output logic              busy,
  output logic              done
);

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     pair_q, pair_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [ACC_W-1:0]    res_data_q, res_data_d;
  logic                mem_en_q, mem_en_d;
  logic                res_valid_q, res_valid_d;
  logic                res_last_q, res_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                mul_start;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_prod;
  logic                handshake;
  logic                last_pair;

  // res_valid is high for the whole of OUT, so ready alone completes the beat.
  assign handshake = (state_q == S_OUT) && res_ready;
  assign last_pair = (pair_q + 1'b1) == len_q;
  // Memory data arrives during WAIT; the multiplier latches it at the end of it.
  assign mul_start = (state_q == S_WAIT);

  seq_multiplier #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (rd_a),
    .b       (rd_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (len == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_MUL;
      S_MUL:   if (mul_done) state_d = S_OUT;
      S_OUT:   if (res_ready) state_d = last_pair ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    mode_d     = mode_q;
    len_d      = len_q;
    pair_d     = pair_q;
    acc_d      = acc_q;
    mem_addr_d = mem_addr_q;
    res_data_d = res_data_q;
    res_last_d = res_last_q;

    if ((state_q == S_IDLE) && start) begin
      mode_d     = mode_acc;
      len_d      = len;
      pair_d     = '0;
      acc_d      = '0;
      mem_addr_d = base_addr;
    end

    if ((state_q == S_MUL) && mul_done) begin
      res_data_d = mode_q ? (acc_q + ACC_W'(mul_prod)) : ACC_W'(mul_prod);
      res_last_d = last_pair;
    end

    if (handshake) begin
      if (mode_q) acc_d = res_data_q;
      pair_d     = pair_q + 1'b1;
      res_last_d = 1'b0;
      // Address wraps naturally modulo 2^ADDR_W.
      if (!last_pair) mem_addr_d = mem_addr_q + 1'b1;
    end

    mem_en_d    = (state_d == S_FETCH);
    res_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= 1'b0;
      len_q       <= '0;
      pair_q      <= '0;
      acc_q       <= '0;
      mem_addr_q  <= '0;
      res_data_q  <= '0;
      mem_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      len_q       <= len_d;
      pair_q      <= pair_d;
      acc_q       <= acc_d;
      mem_addr_q  <= mem_addr_d;
      res_data_q  <= res_data_d;
      mem_en_q    <= mem_en_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign res_last  = res_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bram_mac_sequencer.sv
// Directed bench for bram_mac_sequencer at DATA_W=8, ADDR_W=5.
module tb_bram_mac_sequencer;

  localparam int DW   = 8;
  localparam int AW   = 5;
  localparam int ACCW = 2 * DW + AW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            mode_acc;
  logic [AW-1:0]   base_addr;
  logic [AW:0]     len;
  logic            mem_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   rd_a, rd_b;
  logic [ACCW-1:0] res_data;
  logic            res_valid, res_ready, res_last, busy, done;

  logic [DW-1:0]   mem_a [32];
  logic [DW-1:0]   mem_b [32];

  int total = 0;
  int bad   = 0;

  logic [ACCW-1:0] got_data [40];
  logic            got_last [40];
  logic [AW-1:0]   got_addr [40];
  int              n_res, n_addr, done_cyc, done_width;
  logic            busy_after, stall_moved, fetch_in_stall;

  bram_mac_sequencer #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .ACC_W  (ACCW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode_acc  (mode_acc),
    .base_addr (base_addr),
    .len       (len),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .rd_a      (rd_a),
    .rd_b      (rd_b),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_last  (res_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read operand memories
  always @(posedge clk) begin
    if (mem_en) begin
      rd_a <= mem_a[mem_addr];
      rd_b <= mem_b[mem_addr];
    end
  end

  // Starts a run and records the address stream, accepted results and done
  // timing. Cycle 1 is the first cycle after the accepting edge. Optionally
  // holds res_ready low for 'stall' cycles on the first result and pokes
  // start again while busy.
  task automatic do_run(input logic m, input logic [AW-1:0] b, input logic [AW:0] l,
                        input int stall, input bit poke);
    int scnt;
    logic [ACCW-1:0] held;
    n_res = 0; n_addr = 0; done_cyc = -1; done_width = 0;
    stall_moved = 1'b0; fetch_in_stall = 1'b0; busy_after = 1'b1;
    scnt = 0; held = '0;
    @(negedge clk);
    start = 1'b1; mode_acc = m; base_addr = b; len = l; res_ready = (stall == 0);
    @(negedge clk);
    start = 1'b0; mode_acc = ~m; base_addr = b + 5'd9; len = l + 6'd3;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      start = (poke && cyc == 5);
      if (mem_en) begin
        if (n_addr < 40) got_addr[n_addr] = mem_addr;
        n_addr++;
      end
      if (res_valid && !res_ready && stall > 0) begin
        if (scnt == 0) held = res_data;
        else if (res_data !== held) stall_moved = 1'b1;
        if (scnt == stall) res_ready = 1'b1;
        else scnt++;
      end
      if (scnt > 0 && !res_ready) begin
        if (mem_en) fetch_in_stall = 1'b1;
        if (!res_valid) stall_moved = 1'b1;
      end
      if (res_valid && res_ready) begin
        if (n_res < 40) begin
          got_data[n_res] = res_data;
          got_last[n_res] = res_last;
        end
        n_res++;
      end
      if (done) begin
        if (done_cyc < 0) done_cyc = cyc;
        done_width++;
      end else if (done_cyc >= 0) begin
        busy_after = busy;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    res_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode_acc = 1'b0; base_addr = '0; len = '0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (mem_en !== 1'b0)    begin bad++; $display("FAIL reset_mem_en got=%b want=0", mem_en); end
    total++; if (mem_addr !== '0)    begin bad++; $display("FAIL reset_mem_addr got=%0d want=0", mem_addr); end
    total++; if (res_data !== '0)    begin bad++; $display("FAIL reset_res_data got=%0d want=0", res_data); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    total++; if (res_last !== 1'b0)  begin bad++; $display("FAIL reset_res_last got=%b want=0", res_last); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mode0();
    logic [ACCW-1:0] exp_d [3];
    exp_d[0] = 21'd15; exp_d[1] = 21'd65025; exp_d[2] = 21'd0;
    do_run(1'b0, 5'd0, 6'd3, 0, 1'b0);
    total++; if (n_res !== 3) begin bad++; $display("FAIL m0_count got=%0d want=3", n_res); end
    for (int i = 0; i < 3; i++) begin
      total++; if (got_data[i] !== exp_d[i]) begin bad++; $display("FAIL m0_data[%0d] got=%0d want=%0d", i, got_data[i], exp_d[i]); end
      total++; if (got_last[i] !== (i == 2)) begin bad++; $display("FAIL m0_last[%0d] got=%b want=%b", i, got_last[i], (i == 2)); end
      total++; if (got_addr[i] !== 5'(i)) begin bad++; $display("FAIL m0_addr[%0d] got=%0d want=%0d", i, got_addr[i], i); end
    end
    total++; if (n_addr !== 3) begin bad++; $display("FAIL m0_fetches got=%0d want=3", n_addr); end
    total++; if (done_cyc !== 34) begin bad++; $display("FAIL m0_done_cycle got=%0d want=34", done_cyc); end
    total++; if (done_width !== 1) begin bad++; $display("FAIL m0_done_width got=%0d want=1", done_width); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL m0_busy_after got=%b want=0", busy_after); end
  endtask

  task automatic test_mode1();
    logic [ACCW-1:0] exp_d [3];
    exp_d[0] = 21'd15; exp_d[1] = 21'd65040; exp_d[2] = 21'd65040;
    do_run(1'b1, 5'd0, 6'd3, 0, 1'b0);
    total++; if (n_res !== 3) begin bad++; $display("FAIL m1_count got=%0d want=3", n_res); end
    for (int i = 0; i < 3; i++) begin
      total++; if (got_data[i] !== exp_d[i]) begin bad++; $display("FAIL m1_data[%0d] got=%0d want=%0d", i, got_data[i], exp_d[i]); end
    end
    total++; if (got_last[2] !== 1'b1) begin bad++; $display("FAIL m1_last got=%b want=1", got_last[2]); end
    total++; if (done_cyc !== 34) begin bad++; $display("FAIL m1_done_cycle got=%0d want=34", done_cyc); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0]   exp_a [4];
    logic [ACCW-1:0] exp_d [4];
    exp_a[0] = 5'd30; exp_a[1] = 5'd31; exp_a[2] = 5'd0; exp_a[3] = 5'd1;
    exp_d[0] = 21'd20; exp_d[1] = 21'd24; exp_d[2] = 21'd15; exp_d[3] = 21'd65025;
    do_run(1'b0, 5'd30, 6'd4, 0, 1'b0);
    total++; if (n_addr !== 4) begin bad++; $display("FAIL wrap_fetches got=%0d want=4", n_addr); end
    for (int i = 0; i < 4; i++) begin
      total++; if (got_addr[i] !== exp_a[i]) begin bad++; $display("FAIL wrap_addr[%0d] got=%0d want=%0d", i, got_addr[i], exp_a[i]); end
      total++; if (got_data[i] !== exp_d[i]) begin bad++; $display("FAIL wrap_data[%0d] got=%0d want=%0d", i, got_data[i], exp_d[i]); end
    end
    total++; if (done_cyc !== 45) begin bad++; $display("FAIL wrap_done_cycle got=%0d want=45", done_cyc); end
  endtask

  task automatic test_stall();
    do_run(1'b1, 5'd0, 6'd3, 10, 1'b0);
    total++; if (stall_moved !== 1'b0) begin bad++; $display("FAIL stall_hold got=%b want=0", stall_moved); end
    total++; if (fetch_in_stall !== 1'b0) begin bad++; $display("FAIL stall_no_fetch got=%b want=0", fetch_in_stall); end
    total++; if (n_res !== 3) begin bad++; $display("FAIL stall_count got=%0d want=3", n_res); end
    total++; if (got_data[0] !== 21'd15) begin bad++; $display("FAIL stall_data0 got=%0d want=15", got_data[0]); end
    total++; if (got_data[2] !== 21'd65040) begin bad++; $display("FAIL stall_data2 got=%0d want=65040", got_data[2]); end
    total++; if (done_cyc !== 44) begin bad++; $display("FAIL stall_done_cycle got=%0d want=44", done_cyc); end
  endtask

  task automatic test_len0_and_busy_start();
    do_run(1'b0, 5'd7, 6'd0, 0, 1'b0);
    total++; if (done_cyc !== 1) begin bad++; $display("FAIL len0_done_cycle got=%0d want=1", done_cyc); end
    total++; if (done_width !== 1) begin bad++; $display("FAIL len0_done_width got=%0d want=1", done_width); end
    total++; if (n_addr !== 0) begin bad++; $display("FAIL len0_fetches got=%0d want=0", n_addr); end
    total++; if (n_res !== 0) begin bad++; $display("FAIL len0_results got=%0d want=0", n_res); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL len0_busy_after got=%b want=0", busy_after); end
    // second start arrives mid-run with base 13 / len 5 / mode 0 on the pins
    do_run(1'b1, 5'd4, 6'd2, 0, 1'b1);
    total++; if (n_addr !== 2) begin bad++; $display("FAIL busy_start_fetches got=%0d want=2", n_addr); end
    total++; if (got_addr[0] !== 5'd4 || got_addr[1] !== 5'd5) begin bad++; $display("FAIL busy_start_addr got=%0d,%0d want=4,5", got_addr[0], got_addr[1]); end
    total++; if (got_data[0] !== 21'd42 || got_data[1] !== 21'd123) begin bad++; $display("FAIL busy_start_data got=%0d,%0d want=42,123", got_data[0], got_data[1]); end
    total++; if (done_cyc !== 23) begin bad++; $display("FAIL busy_start_done_cycle got=%0d want=23", done_cyc); end
  endtask

  task automatic test_rst_mid();
    logic saw;
    @(negedge clk);
    start = 1'b1; mode_acc = 1'b0; base_addr = 5'd0; len = 6'd3; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // cycle 1 now; pair 2 multiplies during cycles 14..21
    repeat (15) @(negedge clk);
    total++; if (busy !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL rstmid_pre busy=%b valid=%b want=1,0", busy, res_valid); end
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (mem_addr !== '0 || mem_en !== 1'b0) begin bad++; $display("FAIL rstmid_mem got=%0d/%b want=0/0", mem_addr, mem_en); end
    total++; if (res_data !== '0 || res_valid !== 1'b0 || res_last !== 1'b0) begin bad++; $display("FAIL rstmid_res got=%0d/%b/%b want=0/0/0", res_data, res_valid, res_last); end
    saw = done;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL rstmid_quiet got=%b want=0", saw); end
    do_run(1'b0, 5'd0, 6'd3, 0, 1'b0);
    total++; if (got_data[0] !== 21'd15 || got_data[1] !== 21'd65025 || got_data[2] !== 21'd0) begin bad++; $display("FAIL rstmid_rerun got=%0d,%0d,%0d want=15,65025,0", got_data[0], got_data[1], got_data[2]); end
    total++; if (done_cyc !== 34) begin bad++; $display("FAIL rstmid_rerun_done got=%0d want=34", done_cyc); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[0] = 8'd3;   mem_b[0] = 8'd5;
    mem_a[1] = 8'd255; mem_b[1] = 8'd255;
    mem_a[2] = 8'd0;   mem_b[2] = 8'd7;
    mem_a[4] = 8'd6;   mem_b[4] = 8'd7;
    mem_a[5] = 8'd9;   mem_b[5] = 8'd9;
    mem_a[30] = 8'd2;  mem_b[30] = 8'd10;
    mem_a[31] = 8'd4;  mem_b[31] = 8'd6;

    test_reset();
    test_mode0();
    test_mode1();
    test_wrap();
    test_stall();
    test_len0_and_busy_start();
    test_rst_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_mac_sequencer.md
# bram_mac_sequencer

Parametrised operand-pair engine that walks a run of addresses through two synchronous-read operand memories (A and B), multiplies each pair with an iterative shift-add multiplier, and streams either per-pair products or a running multiply-accumulate total downstream over a valid/ready handshake. It replaces the fixed controller-plus-combinational-multiplier path between the operand BRAMs and the display/LED slicing logic, generalising width, depth and run length and adding an accumulate mode and back-pressure.

## Interface
- DATA_W, 32, operand width in bits
- ADDR_W, 5, operand memory address width (depth 2^ADDR_W)
- ACC_W, 2*DATA_W+ADDR_W, result/accumulator width

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- mode_acc  in  1  0 = per-pair product, 1 = running MAC; latched at start
- base_addr  in  ADDR_W  first address of run; latched at start
- len  in  ADDR_W+1  number of pairs (0..2^ADDR_W); latched at start
- mem_en  out  1  read enable to both memories
- mem_addr  out  ADDR_W  shared read address
- rd_a  in  DATA_W  memory A read data, valid one cycle after mem_en
- rd_b  in  DATA_W  memory B read data, valid one cycle after mem_en
- res_data  out  ACC_W  product (zero-extended) or accumulator value
- res_valid  out  1  res_data valid
- res_ready  in  1  downstream accepts
- res_last  out  1  qualifies the final result of the run
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at run completion

## Operation
- States: IDLE, FETCH, WAIT, MUL, OUT, DONE.
- IDLE: start=1 latches mode_acc, base_addr, len; clears accumulator and pair counter. len=0 -> DONE; else -> FETCH.
- FETCH: mem_en=1, mem_addr=current address; -> WAIT.
- WAIT: captures rd_a/rd_b at end of cycle; -> MUL.
- MUL: shift-add, one multiplier bit per cycle, exactly DATA_W cycles, unsigned; -> OUT.
- OUT: res_valid=1, res_data = product (mode 0) or accumulator+product (mode 1, accumulator updated on handshake). Hold res_data stable until res_valid&res_ready. On handshake: last pair -> DONE; else address+1 -> FETCH.
- DONE: done=1 for one cycle; -> IDLE.
- Address increments modulo 2^ADDR_W (base 30, len 4 reads 30,31,0,1).
- Accumulator sized so 2^ADDR_W full-scale products never overflow; no saturation.
- start while busy is ignored; mode/base/len changes mid-run have no effect.
- rst mid-run: immediate return to IDLE, all outputs to reset values, partial results discarded, no done pulse.

## Timing
- Reset values: mem_en=0, mem_addr=0, res_data=0, res_valid=0, res_last=0, busy=0, done=0.
- start accepted at edge k: FETCH during cycle k+1, WAIT k+2, MUL k+3..k+2+DATA_W, res_valid first high cycle k+3+DATA_W.
- Per pair with res_ready held high: DATA_W+3 cycles; run of N pairs = N*(DATA_W+3) cycles, done in the cycle after the final handshake.
- len=0: busy high for one cycle (DONE), done pulses cycle k+1, no mem_en, no res_valid.
- res_valid never deasserts without a handshake; res_last high only alongside res_valid of the final pair.
- All outputs registered; no combinational path from res_ready to any output.

## Structure
- Shared package: state enum, default DATA_W/ADDR_W constants, ACC_W derivation function.
- One sub-module: seq_multiplier (DATA_W-parameterised shift-add core, start/done handshake, 2*DATA_W product); the FSM, counters and accumulator stay in the top.

## Test plan
- DATA_W=8, mode 0, base 0, len 3, A={3,255,0}, B={5,255,7}, ready high -> results 15, 65025, 0; res_last on third; done one cycle after; 33 cycles total.
- Mode 1, same data -> results 15, 65040, 65040; final accumulator 65040.
- base 30, len 4, ADDR_W=5 -> mem_addr sequence 30,31,0,1.
- res_ready low 10 cycles during OUT -> res_valid and res_data held stable, no FETCH issued; resumes on ready.
- len=0 -> done pulse next cycle, no mem_en, no res_valid; start during busy -> ignored.
- rst asserted during MUL of pair 2 -> all outputs 0 asynchronously, busy=0, no done; fresh start then runs correctly from base.
